// File: rtl/stateful_alu_pkg.sv
// Shared opcodes, control-header layout and FSM states
// for the per-stage stateful ALU.
package stateful_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_LOADD = 4'b0111;

  localparam logic [2:0] SEG_TABLE_ID = 3'd3;

  localparam int MOD_ID_LSB = 368;
  localparam int IDX_LSB    = 384;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_WRITE,
    CFG_FLUSH
  } cfg_state_e;

endpackage

// File: rtl/seg_table_cfg.sv
// Control-stream FSM and 16-entry tenant segment table.
// Matching packets program the table; others are forwarded.
module seg_table_cfg
  import stateful_alu_pkg::*;
#(
  parameter int STAGE_ID = 0,
  parameter int DW       = 512,
  parameter int UW       = 128
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic [DW-1:0]   s_tdata_i,
  input  logic [UW-1:0]   s_tuser_i,
  input  logic [DW/8-1:0] s_tkeep_i,
  input  logic            s_tvalid_i,
  input  logic            s_tlast_i,
  output logic [DW-1:0]   m_tdata_o,
  output logic [UW-1:0]   m_tuser_o,
  output logic [DW/8-1:0] m_tkeep_o,
  output logic            m_tvalid_o,
  output logic            m_tlast_o,
  input  logic [3:0]      rd_idx_i,
  output logic [15:0]     rd_seg_o
);

  localparam logic [4:0] STAGE_BITS = 5'(STAGE_ID);

  cfg_state_e  state_q, state_d;
  logic        first_q, first_d;
  logic [3:0]  idx_q, idx_d;
  logic        fwd;
  logic        tbl_we;
  logic [7:0]  mod_id;
  logic        hit;
  logic [15:0] tbl_q [16];

  assign mod_id = s_tdata_i[MOD_ID_LSB +: 8];
  assign hit    = (mod_id[7:3] == STAGE_BITS) &&
                  (mod_id[2:0] == SEG_TABLE_ID);
  assign rd_seg_o = tbl_q[rd_idx_i];

  // Next state: header decode only on the first beat of a packet
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    idx_d   = idx_q;
    fwd     = 1'b0;
    tbl_we  = 1'b0;
    if (s_tvalid_i) begin
      first_d = s_tlast_i;
      unique case (state_q)
        CFG_IDLE: begin
          if (first_q && hit) begin
            idx_d   = s_tdata_i[IDX_LSB +: 4];
            state_d = CFG_WRITE;
          end else begin
            fwd = 1'b1;
          end
        end
        CFG_WRITE: begin
          tbl_we  = 1'b1;
          state_d = s_tlast_i ? CFG_IDLE : CFG_FLUSH;
        end
        CFG_FLUSH: begin
          if (s_tlast_i) state_d = CFG_IDLE;
        end
        default: state_d = CFG_IDLE;
      endcase
    end
  end

  // FSM state, packet-start tracking and latched table index
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CFG_IDLE;
      first_q <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      idx_q   <= idx_d;
    end
  end

  // Segment table; cleared entries have range 0 (no legal address)
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
    end else if (tbl_we) begin
      tbl_q[idx_q] <= s_tdata_i[15:0];
    end
  end

  // One-cycle forwarding register for non-matching traffic
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_tdata_o  <= '0;
      m_tuser_o  <= '0;
      m_tkeep_o  <= '0;
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
    end else begin
      m_tdata_o  <= fwd ? s_tdata_i : '0;
      m_tuser_o  <= fwd ? s_tuser_i : '0;
      m_tkeep_o  <= fwd ? s_tkeep_i : '0;
      m_tvalid_o <= fwd;
      m_tlast_o  <= fwd & s_tlast_i;
    end
  end

endmodule

// File: rtl/stateful_alu.sv
// Per-stage stateful ALU: ADD/SUB and tenant-isolated
// register memory, two-cycle result latency.
module stateful_alu
  import stateful_alu_pkg::*;
#(
  parameter int STAGE_ID             = 0,
  parameter int ACTION_LEN           = 25,
  parameter int DATA_WIDTH           = 32,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MEM_DEPTH            = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ACTION_LEN-1:0]             action_in,
  input  logic                              action_valid,
  input  logic [DATA_WIDTH-1:0]             operand_1_in,
  input  logic [DATA_WIDTH-1:0]             operand_2_in,
  input  logic [DATA_WIDTH-1:0]             operand_3_in,
  input  logic [11:0]                       vlan_id,
  output logic [DATA_WIDTH-1:0]             container_out,
  output logic                              container_out_valid,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
);

  logic [15:0] seg;
  logic [7:0]  off;
  logic        legal_d;
  logic [7:0]  addr_d;
  logic        unused_ok;

  logic                  s1_valid_q;
  logic [3:0]            s1_op_q;
  logic [DATA_WIDTH-1:0] s1_op1_q, s1_op2_q, s1_op3_q;
  logic [7:0]            s1_addr_q;
  logic                  s1_legal_q;

  logic                  s2_valid_q;
  logic [3:0]            s2_op_q;
  logic [DATA_WIDTH-1:0] s2_op1_q, s2_op2_q, s2_op3_q;
  logic [7:0]            s2_addr_q;
  logic                  s2_legal_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] result_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  assign unused_ok = ^{action_in[ACTION_LEN-5:0],
                       vlan_id[11:8], vlan_id[3:0]};

  seg_table_cfg #(
    .STAGE_ID (STAGE_ID),
    .DW       (C_S_AXIS_DATA_WIDTH),
    .UW       (C_S_AXIS_TUSER_WIDTH)
  ) u_cfg (
    .clk        (clk),
    .rst_i      (rst_n),
    .s_tdata_i  (c_s_axis_tdata),
    .s_tuser_i  (c_s_axis_tuser),
    .s_tkeep_i  (c_s_axis_tkeep),
    .s_tvalid_i (c_s_axis_tvalid),
    .s_tlast_i  (c_s_axis_tlast),
    .m_tdata_o  (c_m_axis_tdata),
    .m_tuser_o  (c_m_axis_tuser),
    .m_tkeep_o  (c_m_axis_tkeep),
    .m_tvalid_o (c_m_axis_tvalid),
    .m_tlast_o  (c_m_axis_tlast),
    .rd_idx_i   (vlan_id[7:4]),
    .rd_seg_o   (seg)
  );

  assign off     = operand_2_in[7:0];
  assign legal_d = off < seg[7:0];
  assign addr_d  = seg[15:8] + off;

  // Pipeline valid bits; reset drops anything in flight
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= action_valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Datapath registers for stage 1 and stage 2
  always_ff @(posedge clk) begin
    s1_op_q    <= action_in[ACTION_LEN-1 -: 4];
    s1_op1_q   <= operand_1_in;
    s1_op2_q   <= operand_2_in;
    s1_op3_q   <= operand_3_in;
    s1_addr_q  <= addr_d;
    s1_legal_q <= legal_d;
    s2_op_q    <= s1_op_q;
    s2_op1_q   <= s1_op1_q;
    s2_op2_q   <= s1_op2_q;
    s2_op3_q   <= s1_op3_q;
    s2_addr_q  <= s1_addr_q;
    s2_legal_q <= s1_legal_q;
  end

  // Stage-2 result select and memory write request
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = s2_op1_q;
    result_d  = s2_op1_q;
    unique case (1'b1)
      s2_op_q == OP_ADD:
        result_d = s2_op2_q + s2_op3_q;
      s2_op_q == OP_SUB:
        result_d = s2_op2_q - s2_op3_q;
      s2_legal_q && s2_op_q == OP_STORE:
        mem_we = 1'b1;
      s2_legal_q && s2_op_q == OP_LOAD:
        result_d = rd_data_q;
      s2_legal_q && s2_op_q == OP_LOADD: begin
        mem_we    = 1'b1;
        mem_wdata = rd_data_q + DATA_WIDTH'(1);
        result_d  = rd_data_q + DATA_WIDTH'(1);
      end
      default: ;
    endcase
    mem_we = mem_we & s2_valid_q;
  end

  // Dual-port RAM; same-cycle write forwards into the read
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[s2_addr_q] <= mem_wdata;
    rd_data_q <= (mem_we && s2_addr_q == s1_addr_q) ?
                 mem_wdata : mem_q[s1_addr_q];
  end

  // Registered result and one-cycle strobe
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      container_out       <= '0;
      container_out_valid <= 1'b0;
    end else begin
      container_out_valid <= s2_valid_q;
      if (s2_valid_q) container_out <= result_d;
    end
  end

endmodule

// File: tb/tb_stateful_alu.sv
// Self-checking bench for stateful_alu with a
// behavioural memory/segment-table reference model.
module tb_stateful_alu;
  import stateful_alu_pkg::*;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [24:0]  action_in;
  logic         action_valid;
  logic [31:0]  operand_1_in, operand_2_in, operand_3_in;
  logic [11:0]  vlan_id;
  logic [31:0]  container_out;
  logic         container_out_valid;
  logic [511:0] s_tdata, m_tdata;
  logic [127:0] s_tuser, m_tuser;
  logic [63:0]  s_tkeep, m_tkeep;
  logic         s_tvalid, m_tvalid, s_tlast, m_tlast;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_base [16];
  logic [7:0]  m_range [16];
  logic [31:0] m_mem [256];
  bit          m_known [256];
  exp_t        q [$];

  always #5 clk = ~clk;

  stateful_alu #(.STAGE_ID(0)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .action_in           (action_in),
    .action_valid        (action_valid),
    .operand_1_in        (operand_1_in),
    .operand_2_in        (operand_2_in),
    .operand_3_in        (operand_3_in),
    .vlan_id             (vlan_id),
    .container_out       (container_out),
    .container_out_valid (container_out_valid),
    .c_s_axis_tdata      (s_tdata),
    .c_s_axis_tuser      (s_tuser),
    .c_s_axis_tkeep      (s_tkeep),
    .c_s_axis_tvalid     (s_tvalid),
    .c_s_axis_tlast      (s_tlast),
    .c_m_axis_tdata      (m_tdata),
    .c_m_axis_tuser      (m_tuser),
    .c_m_axis_tkeep      (m_tkeep),
    .c_m_axis_tvalid     (m_tvalid),
    .c_m_axis_tlast      (m_tlast)
  );

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [31:0] model_exec(
    input logic [3:0] op, input logic [31:0] a1,
    input logic [31:0] a2, input logic [31:0] a3,
    input logic [3:0] ten, output bit chk);
    int off, addr;
    bit ok;
    logic [31:0] r;
    off  = int'(a2[7:0]);
    ok   = off < int'(m_range[ten]);
    addr = (int'(m_base[ten]) + off) % 256;
    chk  = 1'b1;
    r    = a1;
    if (op == OP_ADD) r = a2 + a3;
    else if (op == OP_SUB) r = a2 - a3;
    else if (ok && op == OP_STORE) begin
      m_mem[addr]   = a1;
      m_known[addr] = 1'b1;
    end else if (ok && op == OP_LOAD) begin
      r   = m_mem[addr];
      chk = m_known[addr];
    end else if (ok && op == OP_LOADD) begin
      m_mem[addr] = m_mem[addr] + 32'd1;
      r   = m_mem[addr];
      chk = m_known[addr];
    end
    return r;
  endfunction

  task automatic set_action(input logic [3:0] op,
    input logic [31:0] a1, input logic [31:0] a2,
    input logic [31:0] a3, input logic [3:0] ten);
    action_in    = {op, 21'($urandom)};
    action_valid = 1'b1;
    operand_1_in = a1;
    operand_2_in = a2;
    operand_3_in = a3;
    vlan_id      = {4'($urandom), ten, 4'($urandom)};
  endtask

  task automatic set_idle();
    action_valid = 1'b0;
    action_in    = 25'($urandom);
    operand_1_in = $urandom;
    operand_2_in = $urandom;
    operand_3_in = $urandom;
    vlan_id      = 12'($urandom);
  endtask

  task automatic issue(input logic [3:0] op,
    input logic [31:0] a1, input logic [31:0] a2,
    input logic [31:0] a3, input logic [3:0] ten);
    exp_t e;
    bit c;
    set_action(op, a1, a2, a3, ten);
    e.v   = 1'b1;
    e.d   = model_exec(op, a1, a2, a3, ten, c);
    e.chk = c;
    q.push_back(e);
  endtask

  task automatic issue_idle();
    exp_t e;
    set_idle();
    e.v   = 1'b0;
    e.d   = '0;
    e.chk = 1'b0;
    q.push_back(e);
  endtask

  task automatic drive_beat(input logic [511:0] d,
    input logic [127:0] u, input logic [63:0] k,
    input logic last);
    s_tdata  = d;
    s_tuser  = u;
    s_tkeep  = k;
    s_tvalid = 1'b1;
    s_tlast  = last;
  endtask

  task automatic beat_idle();
    s_tdata  = rand512();
    s_tuser  = rand128();
    s_tkeep  = rand64();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_action(OP_ADD, $urandom, $urandom, $urandom, 4'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (container_out_valid !== 1'b0 || container_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%0b d=%0h required v=0 d=0",
               container_out_valid, container_out);
    end
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tuser !== '0 ||
        m_tkeep !== '0 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_axis: got tvalid=%0b required all zero",
               m_tvalid);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_add_sub();
    @(negedge clk);
    set_action(OP_ADD, $urandom, 32'd3, 32'd12, 4'($urandom));
    @(negedge clk);
    set_action(OP_SUB, $urandom, 32'd3, 32'd12, 4'($urandom));
    checks++;
    if (container_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_early: got v=%0b required 0",
               container_out_valid);
    end
    @(negedge clk);
    set_idle();
    checks++;
    if (container_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_n1: got v=%0b required 0",
               container_out_valid);
    end
    @(negedge clk);
    checks++;
    if (container_out_valid !== 1'b1 || container_out !== 32'd15) begin
      errors++;
      $display("FAIL add: got v=%0b d=%0h required v=1 d=f",
               container_out_valid, container_out);
    end
    @(negedge clk);
    checks++;
    if (container_out_valid !== 1'b1 ||
        container_out !== 32'hFFFF_FFF7) begin
      errors++;
      $display("FAIL sub: got v=%0b d=%0h required v=1 d=fffffff7",
               container_out_valid, container_out);
    end
    @(negedge clk);
    checks++;
    if (container_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL strobe_len: got v=%0b required 0",
               container_out_valid);
    end
  endtask

  task automatic test_ctrl_cfg();
    logic [511:0] d;
    for (int t = 4; t <= 5; t++) begin
      d = rand512();
      d[375:368] = 8'h03;
      d[387:384] = 4'(t);
      @(negedge clk);
      drive_beat(d, rand128(), rand64(), 1'b0);
      d = rand512();
      d[15:0] = 16'h0010;
      @(negedge clk);
      drive_beat(d, rand128(), rand64(), 1'b1);
      checks++;
      if (m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL cfg_hdr_consumed: got tvalid=%0b required 0",
                 m_tvalid);
      end
      @(negedge clk);
      beat_idle();
      checks++;
      if (m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL cfg_data_consumed: got tvalid=%0b required 0",
                 m_tvalid);
      end
      m_base[t]  = 8'h00;
      m_range[t] = 8'h10;
    end
  endtask

  task automatic test_fwd();
    logic [511:0] d [3];
    logic [127:0] u [3];
    logic [63:0]  k [3];
    for (int i = 0; i < 3; i++) begin
      d[i] = rand512();
      u[i] = rand128();
      k[i] = rand64();
    end
    d[0][375:368] = 8'h0B;
    d[1][375:368] = 8'h03;
    d[1][387:384] = 4'h7;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if (j == 0) begin
        if (m_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL fwd_early: got tvalid=%0b required 0",
                   m_tvalid);
        end
      end else if (m_tvalid !== 1'b1 || m_tdata !== d[j-1] ||
                   m_tuser !== u[j-1] || m_tkeep !== k[j-1] ||
                   m_tlast !== 1'(j == 3)) begin
        errors++;
        $display("FAIL fwd_beat%0d: got tvalid=%0b tlast=%0b tkeep=%0h required tvalid=1 tlast=%0b tkeep=%0h",
                 j - 1, m_tvalid, m_tlast, m_tkeep, j == 3, k[j-1]);
      end
      if (j < 3) drive_beat(d[j], u[j], k[j], 1'(j == 2));
      else beat_idle();
    end
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_end: got tvalid=%0b required 0", m_tvalid);
    end
  endtask

  task automatic test_cfg_flush();
    logic [511:0] d;
    logic [7:0] b, r;
    b = 8'($urandom_range(200, 255));
    r = 8'($urandom_range(8, 40));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j > 0) begin
        checks++;
        if (m_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL flush_consumed%0d: got tvalid=%0b required 0",
                   j, m_tvalid);
        end
      end
      d = rand512();
      if (j == 0) begin
        d[375:368] = 8'h03;
        d[387:384] = 4'd6;
      end
      if (j == 1) d[15:0] = {b, r};
      if (j == 2) d[15:0] = {b + 8'd1, 8'd0};
      if (j < 3) drive_beat(d, rand128(), rand64(), 1'(j == 2));
      else begin
        d[375:368] = 8'h0B;
        drive_beat(d, rand128(), rand64(), 1'b1);
      end
    end
    @(negedge clk);
    beat_idle();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== d) begin
      errors++;
      $display("FAIL flush_then_fwd: got tvalid=%0b required 1",
               m_tvalid);
    end
    m_base[6]  = b;
    m_range[6] = r;
  endtask

  task automatic test_mem_directed();
    logic [3:0]  ops [8];
    logic [3:0]  tn [8];
    logic [31:0] a1 [8];
    logic [31:0] a2 [8];
    logic [31:0] ex [8];
    logic [31:0] r;
    bit c;
    ops = '{OP_STORE, OP_LOAD, OP_LOADD, OP_LOADD,
            OP_STORE, OP_LOAD, OP_STORE, OP_LOAD};
    tn  = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd3, 4'd4};
    a2  = '{32'd0, 32'd0, 32'd0, 32'd0,
            32'd16, 32'd16, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) a1[i] = $urandom;
    a1[0] = 32'd20;
    ex = '{32'd20, 32'd20, 32'd21, 32'd22,
           a1[4], a1[5], a1[6], 32'd22};
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      checks++;
      if (j >= 3) begin
        if (container_out_valid !== 1'b1 ||
            container_out !== ex[j-3]) begin
          errors++;
          $display("FAIL mem_dir%0d: got v=%0b d=%0h required v=1 d=%0h",
                   j - 3, container_out_valid, container_out, ex[j-3]);
        end
      end else if (container_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mem_dir_idle: got v=%0b required 0",
                 container_out_valid);
      end
      if (j < 8) begin
        set_action(ops[j], a1[j], a2[j], 32'd0, tn[j]);
        r = model_exec(ops[j], a1[j], a2[j], 32'd0, tn[j], c);
      end else begin
        set_idle();
      end
    end
  endtask

  task automatic test_passthru();
    logic [3:0]  ops [3];
    logic [31:0] a1 [3];
    logic [31:0] ex [3];
    logic [31:0] r;
    bit c;
    ops = '{4'b0011, 4'b1111, OP_LOAD};
    a1  = '{32'd20, $urandom, $urandom};
    ex  = '{32'd20, a1[1], 32'd22};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        checks++;
        if (container_out_valid !== 1'b1 ||
            container_out !== ex[j-3]) begin
          errors++;
          $display("FAIL passthru%0d: got v=%0b d=%0h required v=1 d=%0h",
                   j - 3, container_out_valid, container_out, ex[j-3]);
        end
      end
      if (j < 3) begin
        set_action(ops[j], a1[j], 32'd0, $urandom, 4'd4);
        r = model_exec(ops[j], a1[j], 32'd0, 32'd0, 4'd4, c);
      end else begin
        set_idle();
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int n, sel, t, off, r6;
    logic [3:0] ot;
    r6 = int'(m_range[6]);
    n  = 16 + r6 + 300;
    for (int j = 0; j < n + 3; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        e = q.pop_front();
        checks++;
        if (container_out_valid !== e.v) begin
          errors++;
          $display("FAIL rand_valid%0d: got %0b required %0b",
                   j - 3, container_out_valid, e.v);
        end
        if (e.v && e.chk) begin
          checks++;
          if (container_out !== e.d) begin
            errors++;
            $display("FAIL rand_data%0d: got %0h required %0h",
                     j - 3, container_out, e.d);
          end
        end
      end
      if (j < 16) begin
        issue(OP_STORE, $urandom, 32'(j), $urandom, 4'd4);
      end else if (j < 16 + r6) begin
        issue(OP_STORE, $urandom, 32'(j - 16), $urandom, 4'd6);
      end else if (j < n) begin
        sel = $urandom_range(0, 9);
        t   = $urandom_range(3, 6);
        off = $urandom_range(0, int'(m_range[t]) + 4);
        ot  = 4'($urandom);
        while (ot == OP_ADD || ot == OP_SUB || ot == OP_STORE ||
               ot == OP_LOAD || ot == OP_LOADD) ot = 4'($urandom);
        case (sel)
          0: issue(OP_ADD, $urandom, $urandom, $urandom, 4'(t));
          1: issue(OP_SUB, $urandom, $urandom, $urandom, 4'(t));
          2, 3: issue(OP_STORE, $urandom,
                      {24'($urandom), 8'(off)}, $urandom, 4'(t));
          4, 5: issue(OP_LOAD, $urandom,
                      {24'($urandom), 8'(off)}, $urandom, 4'(t));
          6, 7: issue(OP_LOADD, $urandom,
                      {24'($urandom), 8'(off)}, $urandom, 4'(t));
          8: issue(ot, $urandom, {24'($urandom), 8'(off)},
                   $urandom, 4'(t));
          default: issue_idle();
        endcase
      end else begin
        set_idle();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a1, r;
    logic [31:0] b1 [3];
    logic [3:0]  ops [3];
    bit c;
    a1 = $urandom;
    @(negedge clk);
    set_action(OP_LOAD, a1, 32'd0, $urandom, 4'd4);
    r = model_exec(OP_LOAD, a1, 32'd0, 32'd0, 4'd4, c);
    @(negedge clk);
    set_action(OP_ADD, $urandom, $urandom, $urandom, 4'($urandom));
    @(negedge clk);
    set_idle();
    @(posedge clk);
    #1;
    checks++;
    if (container_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %0b required 1",
               container_out_valid);
    end
    if (c) begin
      checks++;
      if (container_out !== r) begin
        errors++;
        $display("FAIL pre_reset_data: got %0h required %0h",
                 container_out, r);
      end
    end
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (container_out_valid !== 1'b0 || container_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%0b d=%0h required v=0 d=0",
               container_out_valid, container_out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_base[i]  = 8'h00;
      m_range[i] = 8'h00;
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (container_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL inflight_dropped: got v=%0b required 0",
                 container_out_valid);
      end
    end
    ops = '{OP_LOAD, OP_STORE, OP_LOADD};
    for (int i = 0; i < 3; i++) b1[i] = $urandom;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        checks++;
        if (container_out_valid !== 1'b1 ||
            container_out !== b1[j-3]) begin
          errors++;
          $display("FAIL table_cleared%0d: got v=%0b d=%0h required v=1 d=%0h",
                   j - 3, container_out_valid, container_out, b1[j-3]);
        end
      end
      if (j < 3) begin
        set_action(ops[j], b1[j], 32'd0, $urandom, 4'd4);
        r = model_exec(ops[j], b1[j], 32'd0, 32'd0, 4'd4, c);
      end else begin
        set_idle();
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    set_idle();
    beat_idle();
    for (int i = 0; i < 16; i++) begin
      m_base[i]  = 8'h00;
      m_range[i] = 8'h00;
    end
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    test_reset();
    test_add_sub();
    test_ctrl_cfg();
    test_fwd();
    test_cfg_flush();
    test_mem_directed();
    test_passthru();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/stateful_alu.md
Name: stateful_alu

Overview:
- Per-stage stateful ALU of the RMT action engine; one instance per stage, identified by STAGE_ID.
- Executes a single 25-bit action on 32-bit operands: ADD, SUB, or tenant-isolated register-memory STORE/LOAD/LOADD.
- Memory isolation uses a segment table indexed by tenant ID (vlan_id[7:4]); the table is written over the AXI-Stream control path.
- Result returns to PHV assembly.

Parameters:
- STAGE_ID, 0, stage number matched against control-packet module ID bits [7:3].
- ACTION_LEN, 25, action word width.
- DATA_WIDTH, 32, operand/result width.
- C_S_AXIS_DATA_WIDTH, 512, control tdata width.
- C_S_AXIS_TUSER_WIDTH, 128, control tuser width.
- MEM_DEPTH, 256, stateful word count; address is 8 bits.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1 despite the name).
- action_in  in  25  [24:21] opcode, [20:0] unused by this block.
- action_valid  in  1  action/operands/vlan_id valid this cycle.
- operand_1_in, operand_2_in, operand_3_in  in  32 each  container value, offset/A, B.
- vlan_id  in  12  [7:4] = tenant/segment index.
- container_out  out  32  result.
- container_out_valid  out  1  one-cycle result strobe.
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  512/128/64/1/1  control stream in.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  same  control stream out.

Behaviour:
- Reset: container_out=0, container_out_valid=0, all c_m_axis outputs=0, segment table cleared (range=0 makes every address illegal), control FSM to IDLE. Memory contents are not reset.
- Latency: action sampled at edge N produces container_out/valid at edge N+2; valid is high for exactly 1 cycle; one action per cycle is accepted.
- Opcodes:
  - 0001 ADD: out = op2 + op3, mod 2^32.
  - 0010 SUB: out = op2 - op3, mod 2^32.
  - 1000 STORE: mem[addr] <= op1; out = op1.
  - 1011 LOAD: out = mem[addr].
  - 0111 LOADD: mem[addr] <= mem[addr]+1; out = incremented value.
  - Any other opcode: out = op1 (pass-through), valid still pulses, no memory access.
- Addressing: seg = table[vlan_id[7:4]] = {base[7:0], range[7:0]}; off = op2[7:0]; legal if off < range; addr = base + off (8-bit wrap).
- Illegal address on STORE/LOAD/LOADD: no memory write; out = op1.
- Memory: synchronous read in stage 1, write in stage 2. A stage-1 read of the address written in stage 2 the same cycle must return the newly written value (bypass), so back-to-back LOADDs count correctly.
- Control FSM, states IDLE, WRITE, FLUSH:
  - IDLE, tvalid on first beat: if mod_id = tdata[375:368] has [7:3]==STAGE_ID and [2:0]==3, latch idx = tdata[387:384] and go to WRITE; otherwise forward the packet.
  - WRITE: next valid beat writes table[idx] = {tdata[15:8], tdata[7:0]}; go to IDLE if tlast, else FLUSH.
  - FLUSH: discard beats until tlast, then IDLE.
  - Matching packets are consumed, not forwarded.
  - Forwarded packets appear on c_m_axis with 1-cycle register delay, all fields unchanged.
  - tdata[383:376] is reserved and ignored.
  - No backpressure: no tready on either side.
- Table writes take effect for actions sampled on the cycle after the write edge.
- Reset mid-packet returns the FSM to IDLE; remaining beats of that packet are forwarded as if new.

Decomposition:
- Shared package holds opcode constants (OP_ADD, OP_SUB, OP_STORE, OP_LOAD, OP_LOADD), SEG_TABLE_ID=3, and control-header bit positions (MOD_ID_LSB=368, IDX_LSB=384).
- One natural sub-module: seg_table_cfg (control FSM + 16x16 segment table, read port for tenant lookup).
- Memory inferred inline as simple dual-port RAM.

Test Plan:
- Reset, then ADD op2=3, op3=12 -> container_out=15, valid exactly at N+2 for 1 cycle. SUB op2=3, op3=12 -> 0xFFFFFFF7.
- Opcode 0011, op1=20 -> out=20 with valid pulse; no memory change.
- Control packet mod_id=8'h03, idx=4 (and a second for idx=5), beat 2 low 16 bits=16'h0010 -> table base 0, range 16; c_m_axis_tvalid stays 0 for both. A packet with mod_id=8'h0B is forwarded unchanged 1 cycle later.
- vlan_id[7:4]=4, STORE op1=20, op2=0 -> out=20. Then vlan 4 LOAD op2=0 -> 20. LOADD twice back-to-back -> 21, 22.
- vlan_id[7:4]=5 with range 16: STORE op2=16 (off=range) -> out=op1, later LOAD op2=16 -> op1 (illegal). Unconfigured tenant 3 STORE -> out=op1, memory untouched.
- Assert rst_n mid-action -> valid=0 immediately, table cleared, vlan 4 LOAD then returns op1.
